// File: rtl/nibble_serial_cmp_seq.sv
// Serial word comparator: feeds one nibble pair per cycle (MSB first) to an
// external 4-bit magnitude comparator and stops at the first unequal nibble.
module nibble_serial_cmp_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  output logic [3:0]           cmp_a,
  output logic [3:0]           cmp_b,
  input  logic                 cmp_alb,
  input  logic                 cmp_aeb,
  input  logic                 cmp_agb,
  output logic                 busy,
  output logic                 done,
  output logic                 alb_o,
  output logic                 aeb_o,
  output logic                 agb_o,
  output logic                 err_o
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_cmp_a;
  logic [3:0]      r_cmp_b;
  logic            r_busy;
  logic            r_done;
  logic            r_alb;
  logic            r_aeb;
  logic            r_agb;
  logic            r_err;
  logic            w_onehot;

  // Odd popcount, excluding the all-three case, is exactly one bit set.
  assign w_onehot = (cmp_alb ^ cmp_aeb ^ cmp_agb) & ~(cmp_alb & cmp_aeb & cmp_agb);

  // r_a/r_b hold the nibbles not yet presented, left-aligned, so the next
  // comparator nibble is always the top one and no variable index is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= IDX_MAX;
      r_cmp_a <= 4'h0;
      r_cmp_b <= 4'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_alb   <= 1'b0;
      r_aeb   <= 1'b0;
      r_agb   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in << 4;
            r_b     <= b_in << 4;
            r_cmp_a <= a_in[W-1 -: 4];
            r_cmp_b <= b_in[W-1 -: 4];
            r_idx   <= IDX_MAX;
            r_alb   <= 1'b0;
            r_aeb   <= 1'b0;
            r_agb   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_onehot && cmp_aeb && (r_idx != '0)) begin
            r_idx   <= r_idx - IDX_ONE;
            r_cmp_a <= r_a[W-1 -: 4];
            r_cmp_b <= r_b[W-1 -: 4];
            r_a     <= r_a << 4;
            r_b     <= r_b << 4;
          end else begin
            if (w_onehot) begin
              r_alb <= cmp_alb;
              r_aeb <= cmp_aeb;
              r_agb <= cmp_agb;
            end else begin
              r_err <= 1'b1;
            end
            r_cmp_a <= 4'h0;
            r_cmp_b <= 4'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmp_a = r_cmp_a;
  assign cmp_b = r_cmp_b;
  assign busy  = r_busy;
  assign done  = r_done;
  assign alb_o = r_alb;
  assign aeb_o = r_aeb;
  assign agb_o = r_agb;
  assign err_o = r_err;

endmodule

// File: tb/tb_nibble_serial_cmp_seq.sv
// Bench for nibble_serial_cmp_seq: behavioural comparator plus a word-level
// reference model; directed cases followed by randomized operands.
module tb_nibble_serial_cmp_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   cmp_a;
  logic [3:0]   cmp_b;
  logic         cmp_alb;
  logic         cmp_aeb;
  logic         cmp_agb;
  logic         busy;
  logic         done;
  logic         alb_o;
  logic         aeb_o;
  logic         agb_o;
  logic         err_o;
  int           stub;
  int           n_checks = 0;
  int           n_err = 0;

  nibble_serial_cmp_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_alb(cmp_alb), .cmp_aeb(cmp_aeb), .cmp_agb(cmp_agb),
    .busy(busy), .done(done),
    .alb_o(alb_o), .aeb_o(aeb_o), .agb_o(agb_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Comparator: real magnitude compare, or stubbed to a non-one-hot pattern.
  always_comb begin
    cmp_alb = 1'b0;
    cmp_aeb = 1'b0;
    cmp_agb = 1'b0;
    if (stub == 1) begin
      cmp_alb = 1'b1;
      cmp_agb = 1'b1;
    end else if (stub == 0) begin
      cmp_alb = (cmp_a < cmp_b);
      cmp_aeb = (cmp_a == cmp_b);
      cmp_agb = (cmp_a > cmp_b);
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic bz, input logic dn,
                            input logic [3:0] res, input logic [3:0] ca, input logic [3:0] cb);
    check({tag, " busy"}, W'(busy), W'(bz));
    check({tag, " done"}, W'(done), W'(dn));
    check({tag, " result"}, W'({alb_o, aeb_o, agb_o, err_o}), W'(res));
    check({tag, " cmp_a"}, W'(cmp_a), W'(ca));
    check({tag, " cmp_b"}, W'(cmp_b), W'(cmp_b === 4'hx ? 4'h0 : cb));
  endtask

  // Start an operation and follow it cycle by cycle against the model.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stb, input bit disturb, input int hold);
    logic [W-1:0]  diff;
    int            k;
    logic [3:0]    res;
    logic [3:0]    ea;
    logic [3:0]    eb;
    logic [31:0]   rnd;
    diff = a ^ b;
    k = N;
    for (int p = W - 1; p >= 0; p--) begin
      if (diff[p]) begin
        k = N - p / 4;
        break;
      end
    end
    res = {a < b, a == b, a > b, 1'b0};
    if (stb != 0) begin
      k = 1;
      res = 4'b0001;
    end

    @(negedge clk);
    stub  = stb;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < k; j++) begin
      ea = 4'((a >> (4 * (N - 1 - j))) & W'(15));
      eb = 4'((b >> (4 * (N - 1 - j))) & W'(15));
      check_outs($sformatf("%s run%0d", tag, j), 1'b1, 1'b0, 4'b0000, ea, eb);
      if (disturb) begin
        rnd   = $urandom;
        start = 1'b1;
        a_in  = rnd[15:0];
        b_in  = rnd[31:16];
      end
      @(posedge clk);
      #1;
    end
    check_outs({tag, " done"}, 1'b0, 1'b1, res, 4'h0, 4'h0);
    if (disturb) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_outs({tag, " after"}, 1'b0, 1'b0, res, 4'h0, 4'h0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("%s hold%0d", tag, h), 1'b0, 1'b0, res, 4'h0, 4'h0);
    end
    stub = 0;
  endtask

  initial begin
    logic [31:0] r1;
    logic [31:0] r2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int sel;
    int stb;
    stub  = 0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    rst   = 1'b1;
    #1;
    check_outs("reset", 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("equal",   16'h1234, 16'h1234, 0, 1'b0, 0);
    run_op("msb_gt",  16'h8000, 16'h7FFF, 0, 1'b0, 0);
    run_op("third_lt",16'h12A4, 16'h12B4, 0, 1'b0, 5);
    run_op("ignore",  16'h0001, 16'h0002, 0, 1'b1, 0);

    // Reset during the second RUN cycle of an equal-word compare.
    @(negedge clk);
    a_in  = 16'h1234;
    b_in  = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outs("abort", 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    check_outs("abort hold", 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("abort idle", 1'b0, 1'b0, 4'b0000, 4'h0, 4'h0);
    run_op("rerun",   16'h8000, 16'h7FFF, 0, 1'b0, 0);

    run_op("stub2hot",16'h5A5A, 16'h5A5A, 1, 1'b0, 1);
    run_op("stubnone",16'h0F00, 16'h0E00, 2, 1'b0, 0);
    run_op("recover", 16'hFFFF, 16'hFFFE, 0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      r1  = $urandom;
      r2  = $urandom;
      ra  = r1[15:0];
      sel = $urandom_range(0, 3);
      case (sel)
        0: rb = r2[15:0];
        1: rb = ra;
        2: rb = ra ^ (W'(1) << r2[3:0]);
        default: rb = {ra[W-1:4], r2[3:0]};
      endcase
      stb = ($urandom_range(0, 9) == 0) ? 1 + int'($urandom_range(0, 1)) : 0;
      run_op($sformatf("rnd%0d", i), ra, rb, stb, r2[20], int'(r2[22:21]));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
